// File: rtl/pmem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pmem_loader_pkg
// Purpose  : Shared types and constants for the program-memory loader.
//            Holds the loader state encoding, default memory geometry and
//            the byte-stream format constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pmem_loader_pkg;

    // Default geometry of the 256 x 12 program memory
    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 12;
    localparam int MAX_WORDS   = 256;

    // Byte-stream format: the HI byte carries instr[11:8] in its low nibble
    localparam int HI_NIB_LSB  = 8;
    localparam int HI_NIB_W    = 4;
    localparam int LO_BYTE_W   = 8;
    localparam int CSUM_W      = 8;

    // Width of the word counters (must represent MAX_WORDS itself)
    localparam int CNT_W       = 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LO    = 3'd1,
        S_HI    = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    // Clamp a requested word count to the memory size
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] req);
        if (req > CNT_W'(MAX_WORDS))
            return CNT_W'(MAX_WORDS);
        else
            return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmem_csum8.sv
`default_nettype none
// ============================================================================
// Module   : pmem_csum8
// Purpose  : 8-bit modulo-256 running sum of stream bytes.
// Ports    : clk     - system clock, rising edge
//            rst_n   - asynchronous active-low reset (sum -> 0)
//            clr     - synchronous clear, has priority over add_en
//            add_en  - add byte_in to the running sum this cycle
//            byte_in - byte to accumulate
//            sum     - current running sum
// Revision : 1.0 - initial release
// ============================================================================
module pmem_csum8
    import pmem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              add_en,
    input  logic [CSUM_W-1:0] byte_in,
    output logic [CSUM_W-1:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + byte_in;   // natural wrap gives modulo-256
        end
    end

endmodule
`default_nettype wire

// File: rtl/pmem_loader.sv
`default_nettype none
// ============================================================================
// Module   : pmem_loader
// Purpose  : Program-load controller. Receives a byte stream, assembles
//            12-bit instructions from LO/HI byte pairs, writes them to the
//            program memory, holds the core during the load and verifies a
//            trailing 8-bit checksum.
// Ports    : clk, rst_n          - clock / async active-low reset
//            start, count        - begin a load of count words (IDLE only)
//            in_data/valid/ready - byte stream handshake
//            Load_En/Addr/Instr  - program memory write port
//            cpu_hold, busy      - high while a load is in progress
//            done                - one-cycle pulse at end of load
//            err                 - checksum mismatch, sticky until next start
// Revision : 1.0 - initial release
// ============================================================================
module pmem_loader
    import pmem_loader_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   count,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               Load_En,
    output logic [ADDR_W-1:0]  Load_Addr,
    output logic [INSTR_W-1:0] Load_Instr,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     written;
    logic [CNT_W-1:0]     written_nx;
    logic [ADDR_W-1:0]    addr;
    logic [INSTR_W-1:0]   instr;
    logic                 err_r;
    logic [CSUM_W-1:0]    sum;
    logic                 accept;
    logic                 csum_clr;
    logic                 csum_add;

    // All handshake/status outputs decode from the state register only,
    // so there is no combinational path from in_valid to in_ready.
    assign in_ready   = (state == S_LO) || (state == S_HI) || (state == S_CSUM);
    assign Load_En    = (state == S_WRITE);
    assign busy       = (state == S_LO) || (state == S_HI) ||
                        (state == S_WRITE) || (state == S_CSUM);
    assign cpu_hold   = busy;
    assign done       = (state == S_FIN);
    assign err        = err_r;
    assign Load_Addr  = addr;
    assign Load_Instr = instr;

    assign accept     = in_valid && in_ready;
    assign csum_clr   = (state == S_IDLE) && start;
    assign csum_add   = accept && ((state == S_LO) || (state == S_HI));
    assign written_nx = written + CNT_W'(1);

    pmem_csum8 u_csum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (csum_clr),
        .add_en  (csum_add),
        .byte_in (in_data),
        .sum     (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            written <= '0;
            addr    <= '0;
            instr   <= '0;
            err_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt     <= sat_count(count);
                        written <= '0;
                        addr    <= '0;
                        err_r   <= 1'b0;
                        // An empty load still consumes the checksum byte
                        state   <= (count == '0) ? S_CSUM : S_LO;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        instr[LO_BYTE_W-1:0] <= in_data;
                        state                <= S_HI;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        // Upper nibble of the HI byte is checksummed only
                        instr[HI_NIB_LSB +: HI_NIB_W] <= in_data[HI_NIB_W-1:0];
                        state                         <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // addr wraps to 0 after word 255; harmless because the
                    // final word always exits to CSUM here.
                    addr    <= addr + ADDR_W'(1);
                    written <= written_nx;
                    state   <= (written_nx == cnt) ? S_CSUM : S_LO;
                end
                S_CSUM: begin
                    if (accept) begin
                        err_r <= (in_data != sum);
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_loader
// Purpose  : Directed self-checking bench for pmem_loader.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        Load_En;
    logic [7:0]  Load_Addr;
    logic [11:0] Load_Instr;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    pmem_loader #(.ADDR_W(8), .INSTR_W(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .count      (count),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Load_En    (Load_En),
        .Load_Addr  (Load_Addr),
        .Load_Instr (Load_Instr),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write log captured from the memory write port
    logic [7:0]  wr_addr [0:1023];
    logic [11:0] wr_data [0:1023];
    int          wr_cyc  [0:1023];
    int          wr_n = 0;

    always @(negedge clk) begin
        if (Load_En === 1'b1) begin
            check("load_en_with_ready", {31'd0, in_ready}, 32'd0);
            if (wr_n < 1024) begin
                wr_addr[wr_n] = Load_Addr;
                wr_data[wr_n] = Load_Instr;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n++;
        end
    end

    int last_acc;
    int start_cyc;

    task automatic do_start(input logic [8:0] n);
        start     = 1'b1;
        count     = n;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("err_cleared_by_start", {31'd0, err}, 32'd0);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("byte_accept", {31'd0, in_ready}, 32'd1);
        last_acc = cyc;
        @(negedge clk);
    endtask

    task automatic wait_done(input logic exp_err, output int dcyc);
        int t;
        in_valid = 1'b0;
        t = 0;
        while (!done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("hold_low_at_done", {31'd0, cpu_hold}, 32'd0);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        check("ready_low_at_done", {31'd0, in_ready}, 32'd0);
        check("err_at_done", {31'd0, err}, {31'd0, exp_err});
        dcyc = cyc;
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_load_en"},  {31'd0, Load_En}, 32'd0);
        check({tag, "_addr"},     {24'd0, Load_Addr}, 32'd0);
        check({tag, "_instr"},    {20'd0, Load_Instr}, 32'd0);
        check({tag, "_hold"},     {31'd0, cpu_hold}, 32'd0);
        check({tag, "_busy"},     {31'd0, busy}, 32'd0);
        check({tag, "_done"},     {31'd0, done}, 32'd0);
        check({tag, "_err"},      {31'd0, err}, 32'd0);
    endtask

    initial begin
        int base;
        int dcyc;
        int acc;
        int bad_words;
        logic [7:0] sum;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] ib;

        rst_n    = 1'b0;
        start    = 1'b0;
        count    = 9'd0;
        in_data  = 8'd0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- count=2, valid held, good checksum
        base = wr_n;
        do_start(9'd2);
        send(8'h34, 0); send(8'h02, 0); send(8'hCD, 0); send(8'h0A, 0);
        send(8'h0D, 0);
        acc = last_acc;
        wait_done(1'b0, dcyc);
        check("t1_nwr", wr_n - base, 2);
        check("t1_a0", {24'd0, wr_addr[base]}, 32'h0);
        check("t1_d0", {20'd0, wr_data[base]}, 32'h234);
        check("t1_a1", {24'd0, wr_addr[base+1]}, 32'h1);
        check("t1_d1", {20'd0, wr_data[base+1]}, 32'hACD);
        check("t1_wr0_cyc", wr_cyc[base] - start_cyc, 3);
        check("t1_wr1_cyc", wr_cyc[base+1] - start_cyc, 6);
        check("t1_done_after_csum", dcyc - acc, 1);
        check("t1_total_cyc", dcyc - start_cyc, 8);

        // ---- bad checksum: writes still happen, err sticky
        base = wr_n;
        do_start(9'd2);
        send(8'h34, 0); send(8'h02, 0); send(8'hCD, 0); send(8'h0A, 0);
        send(8'h0E, 0);
        wait_done(1'b1, dcyc);
        check("t2_nwr", wr_n - base, 2);
        check("t2_d1", {20'd0, wr_data[base+1]}, 32'hACD);
        repeat (4) @(negedge clk);
        check("t2_err_sticky", {31'd0, err}, 32'd1);

        // ---- random gaps (do_start checks err cleared)
        base = wr_n;
        do_start(9'd2);
        send(8'h34, $urandom_range(0, 5)); send(8'h02, $urandom_range(0, 5));
        send(8'hCD, $urandom_range(0, 5)); send(8'h0A, $urandom_range(0, 5));
        send(8'h0D, $urandom_range(0, 5));
        wait_done(1'b0, dcyc);
        check("t3_nwr", wr_n - base, 2);
        check("t3_d0", {20'd0, wr_data[base]}, 32'h234);
        check("t3_a1", {24'd0, wr_addr[base+1]}, 32'h1);
        check("t3_d1", {20'd0, wr_data[base+1]}, 32'hACD);

        // ---- count=0
        base = wr_n;
        do_start(9'd0);
        send(8'h00, 0);
        wait_done(1'b0, dcyc);
        check("t4_nwr_zero", wr_n - base, 0);

        // ---- count=300 saturates to 256 words
        base = wr_n;
        sum  = 8'h00;
        do_start(9'd300);
        for (int i = 0; i < 256; i++) begin
            ib = 8'(i);
            lo = ib;
            hi = {~ib[3:0], ib[7:4]};
            sum = sum + lo + hi;
            send(lo, 0);
            send(hi, 0);
        end
        send(sum, 0);
        wait_done(1'b0, dcyc);
        check("t5_nwr", wr_n - base, 256);
        bad_words = 0;
        for (int i = 0; i < 256; i++) begin
            ib = 8'(i);
            if (wr_addr[base+i] !== ib || wr_data[base+i] !== {ib[7:4], ib})
                bad_words++;
        end
        check("t5_bad_words", bad_words, 0);
        check("t5_last_addr", {24'd0, wr_addr[base+255]}, 32'hFF);
        check("t5_last_data", {20'd0, wr_data[base+255]}, 32'hFFF);

        // ---- reset after first write of a count=4 load
        base = wr_n;
        do_start(9'd4);
        send(8'h11, 0); send(8'h03, 0);
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_first_write", wr_n - base, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle_after_rst");
        base = wr_n;
        do_start(9'd1);
        send(8'h22, 0); send(8'h01, 0); send(8'h23, 0);
        wait_done(1'b0, dcyc);
        check("t6_nwr", wr_n - base, 1);
        check("t6_a0", {24'd0, wr_addr[base]}, 32'h0);
        check("t6_d0", {20'd0, wr_data[base]}, 32'h122);

        // ---- start pulsed during HI is ignored
        base = wr_n;
        do_start(9'd2);
        send(8'h34, 0);
        start = 1'b1;
        count = 9'd1;
        send(8'h02, 0);
        start = 1'b0;
        count = 9'd0;
        send(8'hCD, 0); send(8'h0A, 0); send(8'h0D, 0);
        wait_done(1'b0, dcyc);
        check("t7_nwr", wr_n - base, 2);
        check("t7_d0", {20'd0, wr_data[base]}, 32'h234);
        check("t7_a1", {24'd0, wr_addr[base+1]}, 32'h1);
        check("t7_d1", {20'd0, wr_data[base+1]}, 32'hACD);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
